// File: rtl/eth_tx_arb_pkg.sv
// Shared types for the MAC TX arbiter and its round-robin selector.
package eth_tx_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_PASS} arb_state_t;

  localparam int unsigned STAT_WIDTH = 16;

endpackage

// File: rtl/eth_arb_rr_select.sv
// Combinational round-robin pick: first set bit of req searched from ptr+1 upward, wrapping.
module eth_arb_rr_select #(
  parameter int unsigned PORTS = 4
) (
  input  logic [PORTS-1:0]         req,
  input  logic [$clog2(PORTS)-1:0] ptr,
  output logic                     any,
  output logic [$clog2(PORTS)-1:0] idx
);

  localparam int unsigned IW = $clog2(PORTS);
  localparam int unsigned DW = $clog2(2 * PORTS);

  logic [2*PORTS-1:0] dbl;
  logic [DW-1:0]      pos;
  logic               found;

  // Doubling the request vector turns the wrap-around search into a linear scan.
  always_comb begin
    dbl   = {req, req};
    any   = |req;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      pos = DW'(ptr) + DW'(k + 1);
      if (!found && dbl[pos]) begin
        found = 1'b1;
        idx   = (pos >= DW'(PORTS)) ? IW'(pos - DW'(PORTS)) : IW'(pos);
      end
    end
  end

endmodule

// File: rtl/eth_mac_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the MAC TX AXI-stream, with a registered output stage.
// Optional per-port packet/abort statistics are compiled in with ETH_TX_ARB_STATS_EN.
module eth_mac_tx_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int unsigned PORTS      = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [PORTS-1:0]            s_axis_tvalid,
  output logic [PORTS-1:0]            s_axis_tready,
  input  logic [PORTS-1:0]            s_axis_tlast,
  input  logic [PORTS-1:0]            s_axis_tuser,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  input  logic [PORTS-1:0]            cfg_port_enable,
  output logic                        grant_valid,
  output logic [$clog2(PORTS)-1:0]    grant_index
`ifdef ETH_TX_ARB_STATS_EN
  ,
  output logic [PORTS*STAT_WIDTH-1:0] stat_pkt_count,
  output logic [PORTS-1:0]            stat_abort_pulse
`endif
);

  localparam int unsigned IW = $clog2(PORTS);

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         grant_index_q, grant_index_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic                  m_tuser_q, m_tuser_d;

  logic [PORTS-1:0]      req;
  logic                  sel_any;
  logic [IW-1:0]         sel_idx;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  g_valid, g_last, g_user;
  logic                  out_ready, s_hs;

  assign req = s_axis_tvalid & cfg_port_enable;

  eth_arb_rr_select #(.PORTS(PORTS)) u_rr_select (
    .req (req),
    .ptr (rr_ptr_q),
    .any (sel_any),
    .idx (sel_idx)
  );

  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_user  = 1'b0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (IW'(p) == grant_index_q) begin
        g_data  = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        g_valid = s_axis_tvalid[p];
        g_last  = s_axis_tlast[p];
        g_user  = s_axis_tuser[p];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_index_d = grant_index_q;
    rr_ptr_d      = rr_ptr_q;
    grant_valid_d = grant_valid_q;
    m_tdata_d     = m_tdata_q;
    m_tvalid_d    = m_tvalid_q;
    m_tlast_d     = m_tlast_q;
    m_tuser_d     = m_tuser_q;
    s_axis_tready = '0;
    out_ready     = !m_tvalid_q || m_axis_tready;
    s_hs          = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (sel_any) begin
          grant_index_d = sel_idx;
          rr_ptr_d      = sel_idx;
          grant_valid_d = 1'b1;
          state_d       = ARB_PASS;
        end
      end
      ARB_PASS: begin
        for (int unsigned p = 0; p < PORTS; p++) begin
          s_axis_tready[p] = (IW'(p) == grant_index_q) && out_ready;
        end
        s_hs = out_ready && g_valid;
        if (s_hs && g_last) begin
          grant_valid_d = 1'b0;
          state_d       = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Loading takes precedence over draining so a simultaneous handshake keeps full throughput.
    if (s_hs) begin
      m_tdata_d  = g_data;
      m_tlast_d  = g_last;
      m_tuser_d  = g_user;
      m_tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      grant_index_q <= '0;
      rr_ptr_q      <= IW'(PORTS - 1);
      grant_valid_q <= 1'b0;
      m_tdata_q     <= '0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tuser_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_index_q <= grant_index_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_valid_q <= grant_valid_d;
      m_tdata_q     <= m_tdata_d;
      m_tvalid_q    <= m_tvalid_d;
      m_tlast_q     <= m_tlast_d;
      m_tuser_q     <= m_tuser_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tuser  = m_tuser_q;
  assign grant_valid   = grant_valid_q;
  assign grant_index   = grant_index_q;

`ifdef ETH_TX_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] pkt_count_q [PORTS];
  logic [STAT_WIDTH-1:0] pkt_count_d [PORTS];
  logic [PORTS-1:0]      abort_pulse_q, abort_pulse_d;

  always_comb begin
    abort_pulse_d  = '0;
    stat_pkt_count = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      pkt_count_d[p] = pkt_count_q[p];
      if (s_hs && g_last && (IW'(p) == grant_index_q)) begin
        pkt_count_d[p]   = pkt_count_q[p] + STAT_WIDTH'(1);
        abort_pulse_d[p] = g_user;
      end
      stat_pkt_count[p*STAT_WIDTH +: STAT_WIDTH] = pkt_count_q[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      abort_pulse_q <= '0;
      for (int unsigned p = 0; p < PORTS; p++) pkt_count_q[p] <= '0;
    end else begin
      abort_pulse_q <= abort_pulse_d;
      for (int unsigned p = 0; p < PORTS; p++) pkt_count_q[p] <= pkt_count_d[p];
    end
  end

  assign stat_abort_pulse = abort_pulse_q;
`endif

endmodule
